stack_ctrl: RTL and testbench

Sequencing controller for the 32x8 latch-based stack storage array. Accepts push/pop commands over a valid/ready handshake and owns the stack pointer. Drives per-entry latch enables and write data with a setup/strobe/hold sequence so latch inputs are stable around the enable pulse. Selects the top entry for reads and returns one response per command.

---
 rtl/stack_pkg.sv | 22 ++
 rtl/stack_wr_decode.sv | 29 ++
 rtl/stack_ctrl.sv | 167 ++++++++++++++++
 tb/tb_stack_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/stack_pkg.sv
// Shared constants, opcodes and state encodings for the stack controller.
package stack_pkg;

  localparam int unsigned DEPTH = 32;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned AW    = 5;

  localparam logic [1:0] OP_PUSH = 2'b00;
  localparam logic [1:0] OP_POP  = 2'b01;
  localparam logic [1:0] OP_PEEK = 2'b10;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE     = 3'd0;
  localparam state_t S_W_SETUP  = 3'd1;
  localparam state_t S_W_STROBE = 3'd2;
  localparam state_t S_W_HOLD   = 3'd3;
  localparam state_t S_R_SEL    = 3'd4;
  localparam state_t S_R_CAP    = 3'd5;
  localparam state_t S_RESP     = 3'd6;

endpackage

// File: rtl/stack_wr_decode.sv
// Registered one-hot latch-enable decoder: the enable for entry sel_i is high
// for exactly the cycle after a strobe_i cycle, and all enables are low otherwise.
module stack_wr_decode #(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned AW    = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             strobe_i,
  input  logic [AW-1:0]    sel_i,
  output logic [DEPTH-1:0] lat_en_o
);

  logic [DEPTH-1:0] lat_en_d;
  logic [DEPTH-1:0] lat_en_q;

  always_comb begin
    lat_en_d = '0;
    if (strobe_i) lat_en_d[sel_i] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) lat_en_q <= '0;
    else      lat_en_q <= lat_en_d;
  end

  assign lat_en_o = lat_en_q;

endmodule

// File: rtl/stack_ctrl.sv
// Push/pop sequencing controller for the latch-based stack array.
// Optional peek command is enabled by defining STACK_CTRL_PEEK_EN.
module stack_ctrl #(
  parameter int unsigned DEPTH = stack_pkg::DEPTH,
  parameter int unsigned WIDTH = stack_pkg::WIDTH,
  parameter int unsigned AW    = stack_pkg::AW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  output logic             rsp_valid,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_err,
  output logic [DEPTH-1:0] lat_en,
  output logic [WIDTH-1:0] lat_d,
  output logic [AW-1:0]    rd_sel,
  input  logic [WIDTH-1:0] rd_q,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty
);

  import stack_pkg::*;

  state_t           state_q, state_d;
  logic [AW:0]      sp_q, sp_d;
  logic [WIDTH-1:0] lat_d_q, lat_d_d;
  logic [AW-1:0]    rd_sel_q, rd_sel_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_err_q, rsp_err_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             reject;
`ifdef STACK_CTRL_PEEK_EN
  logic             peek_q, peek_d;
`endif

  assign full  = (sp_q == (AW+1)'(DEPTH));
  assign empty = (sp_q == '0);

  always_comb begin
    state_d    = state_q;
    sp_d       = sp_q;
    lat_d_d    = lat_d_q;
    rd_sel_d   = rd_sel_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    reject     = 1'b0;
`ifdef STACK_CTRL_PEEK_EN
    peek_d     = peek_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          case (cmd_op)
            OP_PUSH: begin
              if (full) reject = 1'b1;
              else begin
                state_d = S_W_SETUP;
                lat_d_d = cmd_data;
              end
            end
            OP_POP: begin
              if (empty) reject = 1'b1;
              else begin
                state_d  = S_R_SEL;
                rd_sel_d = sp_q[AW-1:0] - AW'(1);
`ifdef STACK_CTRL_PEEK_EN
                peek_d   = 1'b0;
`endif
              end
            end
`ifdef STACK_CTRL_PEEK_EN
            OP_PEEK: begin
              if (empty) reject = 1'b1;
              else begin
                state_d  = S_R_SEL;
                rd_sel_d = sp_q[AW-1:0] - AW'(1);
                peek_d   = 1'b1;
              end
            end
`endif
            default: reject = 1'b1;
          endcase
        end
      end
      S_W_SETUP:  state_d = S_W_STROBE;
      S_W_STROBE: state_d = S_W_HOLD;
      S_W_HOLD: begin
        sp_d       = sp_q + (AW+1)'(1);
        state_d    = S_RESP;
        rsp_data_d = '0;
        rsp_err_d  = 1'b0;
      end
      S_R_SEL:    state_d = S_R_CAP;
      S_R_CAP: begin
`ifdef STACK_CTRL_PEEK_EN
        if (!peek_q) sp_d = sp_q - (AW+1)'(1);
`else
        sp_d = sp_q - (AW+1)'(1);
`endif
        state_d    = S_RESP;
        rsp_data_d = rd_q;
        rsp_err_d  = 1'b0;
      end
      S_RESP:     state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase

    // Rejected commands skip straight to the response with sp/lat_en untouched.
    if (reject) begin
      state_d    = S_RESP;
      rsp_data_d = '0;
      rsp_err_d  = 1'b1;
    end
    rsp_valid_d = (state_d == S_RESP);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      sp_q        <= '0;
      lat_d_q     <= '0;
      rd_sel_q    <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sp_q        <= sp_d;
      lat_d_q     <= lat_d_d;
      rd_sel_q    <= rd_sel_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

`ifdef STACK_CTRL_PEEK_EN
  always_ff @(posedge clk) begin
    if (!rst) peek_q <= 1'b0;
    else      peek_q <= peek_d;
  end
`endif

  stack_wr_decode #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_wr_decode (
    .clk      (clk),
    .rst      (rst),
    .strobe_i (state_q == S_W_SETUP),
    .sel_i    (sp_q[AW-1:0]),
    .lat_en_o (lat_en)
  );

  assign cmd_ready = (state_q == S_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign lat_d     = lat_d_q;
  assign rd_sel    = rd_sel_q;
  assign count     = sp_q;

endmodule

// File: tb/tb_stack_ctrl.sv
// Directed self-checking bench for stack_ctrl with a behavioural latch array.
module tb_stack_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [7:0]  cmd_data;
  logic        rsp_valid;
  logic [7:0]  rsp_data;
  logic        rsp_err;
  logic [31:0] lat_en;
  logic [7:0]  lat_d;
  logic [4:0]  rd_sel;
  logic [7:0]  rd_q;
  logic [5:0]  count;
  logic        full;
  logic        empty;

  int total = 0;
  int bad   = 0;

  logic [7:0] mem [32];

  always #5 clk = ~clk;

  always @(negedge clk)
    for (int i = 0; i < 32; i++)
      if (lat_en[i]) mem[i] <= lat_d;

  assign rd_q = mem[rd_sel];

  stack_ctrl #(
    .DEPTH (32),
    .WIDTH (8),
    .AW    (5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .lat_en    (lat_en),
    .lat_d     (lat_d),
    .rd_sel    (rd_sel),
    .rd_q      (rd_q),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  task automatic apply_reset();
    rst = 1'b0;
    cmd_valid = 1'b0;
    cmd_op = 2'b00;
    cmd_data = 8'h00;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  // Issue one command and follow it to its response (bounded wait).
  task automatic do_cmd(input logic [1:0] op, input logic [7:0] d, output int lat,
                        output logic [7:0] rd, output logic er, output int pulses,
                        output logic [31:0] en_seen);
    lat = -1; rd = 8'h00; er = 1'b0; pulses = 0; en_seen = '0;
    cmd_valid = 1'b1; cmd_op = op; cmd_data = d;
    @(posedge clk);
    #1 cmd_valid = 1'b0; cmd_op = 2'b00; cmd_data = 8'h00;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (lat_en !== '0) begin pulses++; en_seen = lat_en; end
      if (rsp_valid === 1'b1) begin lat = n; rd = rsp_data; er = rsp_err; break; end
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    total++; if (count !== 6'd0) begin bad++; $display("FAIL reset_count: got %0d exp 0", count); end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL reset_empty: got %b exp 1", empty); end
    total++; if (full !== 1'b0) begin bad++; $display("FAIL reset_full: got %b exp 0", full); end
    total++; if (lat_en !== 32'h0) begin bad++; $display("FAIL reset_lat_en: got %h exp 0", lat_en); end
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b exp 1", cmd_ready); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid: got %b exp 0", rsp_valid); end
    total++; if (lat_d !== 8'h00) begin bad++; $display("FAIL reset_lat_d: got %h exp 00", lat_d); end
    total++; if (rd_sel !== 5'd0) begin bad++; $display("FAIL reset_rd_sel: got %0d exp 0", rd_sel); end
    @(posedge clk); #1;
  endtask

  task automatic test_push_timing();
    apply_reset();
    cmd_valid = 1'b1; cmd_op = 2'b00; cmd_data = 8'hA5;
    @(posedge clk);
    #1 cmd_valid = 1'b0; cmd_data = 8'h00;
    @(negedge clk);
    total++; if (lat_d !== 8'hA5) begin bad++; $display("FAIL push_lat_d_T1: got %h exp a5", lat_d); end
    total++; if (lat_en !== 32'h0) begin bad++; $display("FAIL push_en_T1: got %h exp 0", lat_en); end
    total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL push_ready_T1: got %b exp 0", cmd_ready); end
    @(posedge clk); #1; @(negedge clk);
    total++; if (lat_en !== 32'h1) begin bad++; $display("FAIL push_en_T2: got %h exp 1", lat_en); end
    @(posedge clk); #1; @(negedge clk);
    total++; if (lat_en !== 32'h0) begin bad++; $display("FAIL push_en_T3: got %h exp 0", lat_en); end
    total++; if (count !== 6'd0) begin bad++; $display("FAIL push_count_T3: got %0d exp 0", count); end
    total++; if (lat_d !== 8'hA5) begin bad++; $display("FAIL push_lat_d_T3: got %h exp a5", lat_d); end
    @(posedge clk); #1; @(negedge clk);
    total++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0) begin bad++; $display("FAIL push_rsp_T4: got v=%b e=%b exp v=1 e=0", rsp_valid, rsp_err); end
    total++; if (count !== 6'd1) begin bad++; $display("FAIL push_count_T4: got %0d exp 1", count); end
    total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL push_ready_resp: got %b exp 0", cmd_ready); end
    @(posedge clk); #1; @(negedge clk);
    total++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin bad++; $display("FAIL push_after_resp: got v=%b rdy=%b exp v=0 rdy=1", rsp_valid, cmd_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_fill_overflow();
    int lat; logic [7:0] rd; logic er; int pulses; logic [31:0] en;
    apply_reset();
    for (int i = 0; i < 32; i++) begin
      do_cmd(2'b00, 8'(i), lat, rd, er, pulses, en);
      total++;
      if (lat !== 4 || er !== 1'b0 || pulses !== 1 || en !== (32'h1 << i)) begin
        bad++; $display("FAIL fill_push_%0d: got lat=%0d err=%b pulses=%0d en=%h exp lat=4 err=0 pulses=1 en=%h", i, lat, er, pulses, en, 32'h1 << i);
      end
    end
    @(negedge clk);
    total++; if (full !== 1'b1 || count !== 6'd32) begin bad++; $display("FAIL fill_full: got full=%b count=%0d exp 1/32", full, count); end
    @(posedge clk); #1;
    do_cmd(2'b00, 8'hFF, lat, rd, er, pulses, en);
    total++; if (lat !== 1 || er !== 1'b1 || rd !== 8'h00) begin bad++; $display("FAIL overflow_rsp: got lat=%0d err=%b data=%h exp 1/1/00", lat, er, rd); end
    total++; if (pulses !== 0) begin bad++; $display("FAIL overflow_no_pulse: got %0d exp 0", pulses); end
    @(negedge clk);
    total++; if (count !== 6'd32 || lat_d !== 8'h1F) begin bad++; $display("FAIL overflow_state: got count=%0d lat_d=%h exp 32/1f", count, lat_d); end
    @(posedge clk); #1;
  endtask

  task automatic test_drain_underflow();
    int lat; logic [7:0] rd; logic er; int pulses; logic [31:0] en;
    for (int i = 0; i < 32; i++) begin
      do_cmd(2'b01, 8'h00, lat, rd, er, pulses, en);
      total++;
      if (lat !== 3 || er !== 1'b0 || rd !== 8'(31 - i) || pulses !== 0) begin
        bad++; $display("FAIL drain_pop_%0d: got lat=%0d err=%b data=%h pulses=%0d exp lat=3 err=0 data=%h pulses=0", i, lat, er, rd, pulses, 8'(31 - i));
      end
    end
    do_cmd(2'b01, 8'h00, lat, rd, er, pulses, en);
    total++; if (lat !== 1 || er !== 1'b1 || rd !== 8'h00) begin bad++; $display("FAIL underflow_rsp: got lat=%0d err=%b data=%h exp 1/1/00", lat, er, rd); end
    @(negedge clk);
    total++; if (empty !== 1'b1 || count !== 6'd0) begin bad++; $display("FAIL underflow_state: got empty=%b count=%0d exp 1/0", empty, count); end
    @(posedge clk); #1;
  endtask

  task automatic test_illegal();
    int lat; logic [7:0] rd; logic er; int pulses; logic [31:0] en;
    apply_reset();
    do_cmd(2'b00, 8'h5A, lat, rd, er, pulses, en);
    do_cmd(2'b11, 8'h77, lat, rd, er, pulses, en);
    total++; if (lat !== 1 || er !== 1'b1 || rd !== 8'h00 || pulses !== 0) begin bad++; $display("FAIL illegal_rsp: got lat=%0d err=%b data=%h pulses=%0d exp 1/1/00/0", lat, er, rd, pulses); end
    @(negedge clk);
    total++; if (count !== 6'd1) begin bad++; $display("FAIL illegal_count: got %0d exp 1", count); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_push();
    int seen_rsp; int seen_en;
    apply_reset();
    cmd_valid = 1'b1; cmd_op = 2'b00; cmd_data = 8'h3C;
    @(posedge clk);
    #1 cmd_valid = 1'b0; cmd_data = 8'h00;
    @(posedge clk); #1;
    @(negedge clk);
    total++; if (lat_en !== 32'h1) begin bad++; $display("FAIL midrst_strobe: got %h exp 1", lat_en); end
    rst = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    total++; if (lat_en !== 32'h0 || cmd_ready !== 1'b1 || count !== 6'd0) begin bad++; $display("FAIL midrst_after: got en=%h rdy=%b count=%0d exp 0/1/0", lat_en, cmd_ready, count); end
    rst = 1'b1;
    seen_rsp = 0; seen_en = 0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) seen_rsp++;
      if (lat_en !== '0) seen_en++;
    end
    total++; if (seen_rsp !== 0 || seen_en !== 0) begin bad++; $display("FAIL midrst_quiet: got rsp=%0d en=%0d exp 0/0", seen_rsp, seen_en); end
    @(posedge clk); #1;
  endtask

  task automatic test_peek();
    int lat; logic [7:0] rd; logic er; int pulses; logic [31:0] en;
    apply_reset();
    do_cmd(2'b00, 8'h11, lat, rd, er, pulses, en);
    do_cmd(2'b00, 8'h22, lat, rd, er, pulses, en);
    do_cmd(2'b10, 8'h00, lat, rd, er, pulses, en);
`ifdef STACK_CTRL_PEEK_EN
    total++; if (lat !== 3 || er !== 1'b0 || rd !== 8'h22) begin bad++; $display("FAIL peek_rsp: got lat=%0d err=%b data=%h exp 3/0/22", lat, er, rd); end
`else
    total++; if (lat !== 1 || er !== 1'b1 || rd !== 8'h00) begin bad++; $display("FAIL peek_illegal: got lat=%0d err=%b data=%h exp 1/1/00", lat, er, rd); end
`endif
    @(negedge clk);
    total++; if (count !== 6'd2) begin bad++; $display("FAIL peek_count: got %0d exp 2", count); end
    @(posedge clk); #1;
    do_cmd(2'b01, 8'h00, lat, rd, er, pulses, en);
    total++; if (rd !== 8'h22 || er !== 1'b0) begin bad++; $display("FAIL peek_then_pop: got data=%h err=%b exp 22/0", rd, er); end
  endtask

  initial begin
    rst = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_data = 8'h00;
    test_reset();
    test_push_timing();
    test_fill_overflow();
    test_drain_underflow();
    test_illegal();
    test_reset_mid_push();
    test_peek();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
